ucode_sequencer: RTL and testbench
==================================

// Module: ucode_sequencer
// PURPOSE
//  Parametrised microcode engine: writable control store plus micro-PC sequencer.
//  Successor to the fixed 64x27 ROM lookups. Adds runtime patching, branch/call/return
//  sequencing, stall and a start/done handshake. One microword is issued per sys_clk.
//  Sits between a unit's command decoder and its datapath; z drives the datapath controls.
// PARAMETERS
//  AW        6           control-store address width; DEPTH = 2**AW words
//  DW        32          microword width; must be >= AW+2+CSW
//  CSW       2           condition-select width; the cond bus is 2**CSW bits
//  STK       4           return-stack depth, 1..8
//  INIT_FILE "mcode.mif" control-store init image ($readmemh .rom under SIMULATION)
// PORTS
//  sys_clk    in   1       sole clock, rising edge
//  resetl     in   1       asynchronous active-low reset
//  start      in   1       begin execution at start_addr; honoured only when busy=0
//  start_addr in   AW      entry point
//  stall      in   1       freeze sequencer and outputs this cycle
//  cond       in   2**CSW  branch condition inputs, sampled on the cycle the word is in z
//  wr_en      in   1       control-store write strobe; honoured only when busy=0
//  wr_addr    in   AW      write address
//  wr_data    in   DW      write data
//  z          out  DW      current microword
//  z_valid    out  1       z holds an executing word
//  upc        out  AW      address of the word in z
//  busy       out  1       sequencer is running
//  done       out  1       one-cycle pulse on normal completion
//  err        out  1       sticky stack overflow
// BEHAVIOUR
//  Reset (async, resetl=0): z=0, z_valid=0, upc=0, busy=0, done=0, err=0, sp=0, state=IDLE.
//   Reset mid-run aborts immediately. Store contents are NOT reset.
//  Word fields: [AW-1:0]=target, [AW+1:AW]=op, [AW+2+CSW-1:AW+2]=csel; higher bits are free.
//  ops: 00 CONT  next=upc+1
//       01 BR    next = cond[csel] ? target : upc+1
//       10 CALL  push upc+1; next=target
//       11 RET   stack non-empty: pop -> next; stack empty: end of routine
//  The store read is synchronous (1 cycle). The address presented at edge n appears in z
//   after edge n+1. next is combinational from z/cond/stack and feeds the store address.
//  upc+1 wraps from DEPTH-1 to 0 with no flag.
//  States:
//   IDLE: busy=0, z_valid=0. start=1 -> RUN; issues start_addr; clears err.
//    z_valid rises 1 cycle after start.
//   RUN:  busy=1, z_valid=1 from the first word on. Each non-stalled cycle executes the op.
//    RET with sp=0 -> IDLE. done=1 on the following cycle, together with busy=0 and z_valid=0.
//    CALL with sp=STK -> ERR. err=1, z_valid=0, no push.
//   ERR:  busy=0, err held. A start restarts the sequencer (-> RUN, err cleared).
//  stall=1: z, upc, z_valid, sp and state are held, and cond is ignored.
//   stall in IDLE has no effect on start.
//  start while busy=1 is ignored. wr_en while busy=1 is ignored, and the store is unchanged.
//  wr_en and start in the same IDLE cycle: the write completes. If wr_addr==start_addr,
//   the first word read is the OLD data (read-before-write).
//  done is a single-cycle pulse; it never overlaps z_valid.
// STRUCTURE
//  ucode_pkg:
//   - op encodings OP_CONT/OP_BR/OP_CALL/OP_RET
//   - state encodings S_IDLE/S_RUN/S_ERR
//   - field-position functions of AW/CSW
//  Sub-module ucode_store: 1R1W synchronous RAM, DEPTH x DW, loaded from INIT_FILE,
//   read-before-write. It uses an altsyncram DUAL_PORT instance, or an inferred array
//   under SIMULATION.
//  Top level holds: the sequencer FSM, next-address mux, return stack (STK x AW) and sp.
// TESTING
//  1 Straight line: image 0..3 CONT, 4 RET; start, start_addr=0
//    -> z_valid 5 cycles, upc 0,1,2,3,4; done pulses 1 cycle after upc=4.
//  2 Branch: word 2 = BR csel=1 target=10
//    -> cond=4'b0010 gives upc 2->10; cond=4'b0000 gives upc 2->3.
//  3 Call/return: 0 CALL 8, 8 CALL 12, 12 RET, 9 RET, 1 RET
//    -> upc 0,8,12,9,1; done asserted; sp=0 at end.
//  4 Overflow: STK=4, word 5 = CALL 5 -> err=1 after the 5th CALL, busy=0;
//    start -> err=0, busy=1.
//  5 Stall/wrap: AW=6; start_addr=63 (CONT), 0 RET; stall for 3 cycles on upc=63
//    -> z held 3 cycles, then upc=0, then done.
//  6 Patch/reset: write word 7 while busy -> no change; write in IDLE -> new word executes.
//    resetl low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared encodings and microword field positions for the microcode sequencer.
package ucode_pkg;

  typedef enum logic [1:0] {
    OP_CONT = 2'b00,
    OP_BR   = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_ERR  = 2'b10
  } state_e;

  // Microword layout: [AW-1:0] target, [AW+1:AW] op, [AW+2+CSW-1:AW+2] csel.
  function automatic int op_lsb(input int aw);
    return aw;
  endfunction

  function automatic int csel_lsb(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/ucode_store.sv
// Writable control store: 1R1W synchronous RAM with read-before-write on address collision.
module ucode_store #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter     INIT_FILE = "mcode.mif"
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] w_q;
  logic          r_q_live;

`ifdef ALTERA_RESERVED_QIS
  altsyncram #(
    .operation_mode                     ("DUAL_PORT"),
    .width_a                            (DW),
    .widthad_a                          (AW),
    .numwords_a                         (2**AW),
    .width_b                            (DW),
    .widthad_b                          (AW),
    .numwords_b                         (2**AW),
    .address_reg_b                      ("CLOCK0"),
    .rdcontrol_reg_b                    ("CLOCK0"),
    .outdata_reg_b                      ("UNREGISTERED"),
    .read_during_write_mode_mixed_ports ("OLD_DATA"),
    .init_file                          (INIT_FILE),
    .lpm_type                           ("altsyncram")
  ) u_ram (
    .clock0    (sys_clk),
    .wren_a    (i_wr_en),
    .address_a (i_wr_addr),
    .data_a    (i_wr_data),
    .rden_b    (i_rd_en),
    .address_b (i_rd_addr),
    .q_b       (w_q)
  );
`else
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  // NOTE: non-blocking assignments make the read sample the pre-write contents,
  // which is exactly the read-before-write behaviour the sequencer relies on.
  always_ff @(posedge sys_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_q <= r_mem[i_rd_addr];
  end

  assign w_q = r_q;
`endif

  // The RAM output cannot be cleared, so the word is masked until the first read.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)      r_q_live <= 1'b0;
    else if (i_rd_en) r_q_live <= 1'b1;
  end

  assign o_rd_data = r_q_live ? w_q : '0;

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode engine: writable control store plus micro-PC sequencer with
// branch/call/return, stall and a start/done handshake.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int CSW       = 2,
  parameter int STK       = 4,
  parameter     INIT_FILE = "mcode.mif"
) (
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic              stall,
  input  logic [2**CSW-1:0] cond,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     z,
  output logic              z_valid,
  output logic [AW-1:0]     upc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int OP_LSB   = op_lsb(AW);
  localparam int CSEL_LSB = csel_lsb(AW);
  localparam int SPW      = $clog2(STK + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STK);

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_upc;
  logic [SPW-1:0]  r_sp;
  logic [AW-1:0]   r_stack [2**SPW];
  logic            r_done, r_err;

  logic [DW-1:0]   w_z;
  op_e             w_op;
  logic [AW-1:0]   w_tgt, w_upc_inc, w_next, w_rd_addr;
  logic [CSW-1:0]  w_csel;
  logic [SPW-1:0]  w_sp_dec;
  logic            w_sp_empty, w_sp_full, w_push, w_pop;
  logic            w_step, w_launch, w_rd_en, w_wr_en;

  assign w_op       = op_e'(w_z[OP_LSB +: 2]);
  assign w_tgt      = w_z[AW-1:0];
  assign w_csel     = w_z[CSEL_LSB +: CSW];
  assign w_upc_inc  = r_upc + AW'(1);
  assign w_sp_dec   = r_sp - SPW'(1);
  assign w_sp_empty = (r_sp == '0);
  assign w_sp_full  = (r_sp == SP_FULL);

  assign w_step    = (r_state == S_RUN) && !stall;
  assign w_launch  = (r_state != S_RUN) && start;
  assign w_rd_en   = w_launch || (w_step && (w_state_nxt == S_RUN));
  assign w_rd_addr = (r_state == S_RUN) ? w_next : start_addr;
  assign w_wr_en   = wr_en && (r_state != S_RUN);

  ucode_store #(
    .AW        (AW),
    .DW        (DW),
    .INIT_FILE (INIT_FILE)
  ) u_store (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_z)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = w_upc_inc;
    w_push = 1'b0;
    w_pop  = 1'b0;
    unique case (w_op)
      OP_BR:   if (cond[w_csel]) w_next = w_tgt;
      OP_CALL: begin
        w_next = w_tgt;
        w_push = !w_sp_full;
      end
      OP_RET:  if (!w_sp_empty) begin
        w_next = r_stack[w_sp_dec];
        w_pop  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_ERR: if (start) w_state_nxt = S_RUN;
      S_RUN: if (!stall) begin
        if (w_op == OP_RET && w_sp_empty)     w_state_nxt = S_IDLE;
        else if (w_op == OP_CALL && w_sp_full) w_state_nxt = S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_IDLE;
      r_upc   <= '0;
      r_sp    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_step && (w_state_nxt == S_IDLE);
      if (w_rd_en) r_upc <= w_rd_addr;
      if (w_launch) begin
        r_sp  <= '0;
        r_err <= 1'b0;
      end else if (w_step) begin
        if (w_push)     r_sp <= r_sp + SPW'(1);
        else if (w_pop) r_sp <= w_sp_dec;
        if (w_state_nxt == S_ERR) r_err <= 1'b1;
      end
    end
  end

  // NOTE: stack entries are only read below sp, so they carry no reset and
  // can map onto plain registers or distributed RAM.
  always_ff @(posedge sys_clk) begin
    if (w_step && w_push) r_stack[r_sp] <= w_upc_inc;
  end

  always_comb begin
    busy    = (r_state == S_RUN);
    z_valid = (r_state == S_RUN);
    done    = r_done;
    err     = r_err;
    upc     = r_upc;
    z       = w_z;
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: per-cycle vector tables plus hand-written
// sequences for patching, read-before-write and asynchronous reset.
module tb_ucode_sequencer;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int CSW = 2;
  localparam int STK = 4;

  logic              sys_clk = 1'b0;
  logic              resetl, start, stall, wr_en;
  logic [AW-1:0]     start_addr, wr_addr, upc;
  logic [2**CSW-1:0] cond;
  logic [DW-1:0]     wr_data, z;
  logic              z_valid, busy, done, err;

  always #5 sys_clk = ~sys_clk;

  ucode_sequencer #(
    .AW        (AW),
    .DW        (DW),
    .CSW       (CSW),
    .STK       (STK),
    .INIT_FILE ("")
  ) dut (
    .sys_clk    (sys_clk),
    .resetl     (resetl),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .cond       (cond),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .z          (z),
    .z_valid    (z_valid),
    .upc        (upc),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic          start;
    logic [AW-1:0] saddr;
    logic          stall;
    logic [3:0]    cond;
    logic          zv, bsy, dn, er;
    logic [AW-1:0] pc;
    logic          chk_z;
    logic [DW-1:0] zw;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [1:0] CONT = 2'b00, BR = 2'b01, CALL = 2'b10, RET = 2'b11;

  function automatic logic [DW-1:0] mkw(input logic [21:0] f, input logic [1:0] cs,
                                        input logic [1:0] op, input logic [5:0] t);
    return {f, cs, op, t};
  endfunction

  function automatic void add(input logic st, input logic [AW-1:0] sa, input logic sl,
                              input logic [3:0] cd, input logic zv, input logic bsy,
                              input logic dn, input logic er, input logic [AW-1:0] pc,
                              input logic cz, input logic [DW-1:0] zw);
    vec_t v;
    v.start = st; v.saddr = sa; v.stall = sl; v.cond = cd;
    v.zv = zv; v.bsy = bsy; v.dn = dn; v.er = er; v.pc = pc;
    v.chk_z = cz; v.zw = zw;
    vt.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_seg(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      start = vt[i].start; start_addr = vt[i].saddr;
      stall = vt[i].stall; cond = vt[i].cond;
      tick();
      check($sformatf("%s v%0d {zv,busy,done,err,upc}", tag, i - lo),
            {z_valid, busy, done, err, upc},
            {vt[i].zv, vt[i].bsy, vt[i].dn, vt[i].er, vt[i].pc});
      if (vt[i].chk_z) check($sformatf("%s v%0d z", tag, i - lo), z, vt[i].zw);
    end
    start = 1'b0; stall = 1'b0; cond = '0;
  endtask

  task automatic go(input logic [AW-1:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  int s1, s2a, s2b, s3, s4, s5, s_end;

  initial begin
    resetl = 1'b0; start = 1'b0; stall = 1'b0; wr_en = 1'b0;
    start_addr = '0; wr_addr = '0; wr_data = '0; cond = '0;

    // Straight line 0..3 CONT, 4 RET; stall at start and a start while busy are ignored.
    s1 = vt.size();
    add(1, 0,  1, 0, 1, 1, 0, 0, 0, 1, mkw(22'h100, 0, CONT, 0));
    add(0, 0,  0, 0, 1, 1, 0, 0, 1, 0, '0);
    add(1, 20, 0, 0, 1, 1, 0, 0, 2, 0, '0);
    add(0, 0,  0, 0, 1, 1, 0, 0, 3, 0, '0);
    add(0, 0,  0, 0, 1, 1, 0, 0, 4, 1, mkw(22'h104, 0, RET, 0));
    add(0, 0,  0, 0, 0, 0, 1, 0, 4, 0, '0);
    add(0, 0,  0, 0, 0, 0, 0, 0, 4, 0, '0);
    // Branch taken (cond[1]=1) from word 2 to 10.
    s2a = vt.size();
    add(1, 0, 0, 0,       1, 1, 0, 0, 0,  0, '0);
    add(0, 0, 0, 0,       1, 1, 0, 0, 1,  0, '0);
    add(0, 0, 0, 0,       1, 1, 0, 0, 2,  1, mkw(22'h200, 1, BR, 10));
    add(0, 0, 0, 4'b0010, 1, 1, 0, 0, 10, 1, mkw(22'h20A, 0, RET, 0));
    add(0, 0, 0, 0,       0, 0, 1, 0, 10, 0, '0);
    // Branch not taken: every condition bit except the selected one is set.
    s2b = vt.size();
    add(1, 2, 0, 0,       1, 1, 0, 0, 2, 0, '0);
    add(0, 0, 0, 4'b1101, 1, 1, 0, 0, 3, 1, mkw(22'h103, 0, CONT, 0));
    add(0, 0, 0, 0,       1, 1, 0, 0, 4, 0, '0);
    add(0, 0, 0, 0,       0, 0, 1, 0, 4, 0, '0);
    // Nested call/return with a stall on the inner CALL.
    s3 = vt.size();
    add(1, 0, 0, 0, 1, 1, 0, 0, 0,  1, mkw(22'h300, 0, CALL, 8));
    add(0, 0, 0, 0, 1, 1, 0, 0, 8,  0, '0);
    add(0, 0, 1, 0, 1, 1, 0, 0, 8,  1, mkw(22'h308, 0, CALL, 12));
    add(0, 0, 0, 0, 1, 1, 0, 0, 12, 0, '0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 9,  0, '0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1,  0, '0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1,  0, '0);
    // Overflow: word 5 calls itself; the 5th CALL hits a full stack.
    s4 = vt.size();
    for (int r = 0; r < 2; r++) begin
      add(1, 5, 0, 0, 1, 1, 0, 0, 5, 0, '0);
      for (int k = 0; k < STK; k++) add(0, 0, 0, 0, 1, 1, 0, 0, 5, 0, '0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, '0);
      if (r == 0) add(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, '0);
    end
    // Stall three cycles on word 63, then wrap to 0 and return.
    s5 = vt.size();
    add(1, 63, 0, 0, 1, 1, 0, 0, 63, 1, mkw(22'h53F, 0, CONT, 0));
    for (int k = 0; k < 3; k++) add(0, 0, 1, 4'hF, 1, 1, 0, 0, 63, 1, mkw(22'h53F, 0, CONT, 0));
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, mkw(22'h500, 0, RET, 0));
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0);
    s_end = vt.size();

    #12;
    check("reset {zv,busy,done,err,upc}", {z_valid, busy, done, err, upc}, '0);
    check("reset z", z, '0);
    resetl = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) wr(AW'(i), mkw(22'h100 + 22'(i), 0, CONT, 0));
    wr(4, mkw(22'h104, 0, RET, 0));
    run_seg("line", s1, s2a);

    wr(2, mkw(22'h200, 1, BR, 10));
    wr(10, mkw(22'h20A, 0, RET, 0));
    run_seg("br_taken", s2a, s2b);
    run_seg("br_not_taken", s2b, s3);

    wr(0, mkw(22'h300, 0, CALL, 8));
    wr(8, mkw(22'h308, 0, CALL, 12));
    wr(12, mkw(22'h30C, 0, RET, 0));
    wr(9, mkw(22'h309, 0, RET, 0));
    wr(1, mkw(22'h301, 0, RET, 0));
    run_seg("call_ret", s3, s4);
    check("call_ret sp at end", 64'(dut.r_sp), 0);

    wr(5, mkw(22'h405, 0, CALL, 5));
    run_seg("overflow", s4, s5);

    wr(63, mkw(22'h53F, 0, CONT, 0));
    wr(0, mkw(22'h500, 0, RET, 0));
    run_seg("stall_wrap", s5, s_end);

    // Patching: writes while busy are dropped, writes in IDLE take effect.
    wr(6, mkw(22'h606, 0, CONT, 0));
    wr(7, mkw(22'h611, 0, RET, 0));
    go(6);
    check("patch run {busy,upc}", {busy, upc}, {1'b1, 6'd6});
    wr(7, mkw(22'h622, 0, RET, 0));
    check("patch busy-write z", z, mkw(22'h611, 0, RET, 0));
    tick();
    check("patch run {done,busy}", {done, busy}, 2'b10);
    go(7);
    check("patch store unchanged", z, mkw(22'h611, 0, RET, 0));
    tick();
    wr(7, mkw(22'h622, 0, RET, 0));
    go(7);
    check("patch idle write executes", z, mkw(22'h622, 0, RET, 0));
    tick();
    check("patch idle run done", done, 1'b1);

    // Write and start to the same address in one cycle: old word is issued.
    wr_en = 1'b1; wr_addr = 7; wr_data = mkw(22'h633, 0, RET, 0);
    go(7);
    wr_en = 1'b0;
    check("rbw first word old", z, mkw(22'h622, 0, RET, 0));
    tick();
    go(7);
    check("rbw write landed", z, mkw(22'h633, 0, RET, 0));
    tick();

    // Asynchronous reset mid-run; the store keeps its contents.
    go(6);
    check("areset pre {busy,upc}", {busy, upc}, {1'b1, 6'd6});
    #2 resetl = 1'b0;
    #1;
    check("areset {zv,busy,done,err,upc}", {z_valid, busy, done, err, upc}, '0);
    check("areset z", z, '0);
    #2 resetl = 1'b1;
    tick();
    check("post-reset idle {zv,busy,done,err}", {z_valid, busy, done, err}, '0);
    go(7);
    check("store survives reset", z, mkw(22'h633, 0, RET, 0));
    tick();
    check("store survives reset done", {done, busy}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
